// File: rtl/ingress_pkg.sv
// Shared constants, write-side state type and helpers for the ingress packet filter.
package ingress_pkg;

  localparam logic [47:0] FEP_HEADER   = 48'h1ead_feb5_ac0d;
  localparam logic [15:0] IPV4_TYPE    = 16'h0800;
  localparam logic [15:0] IPV6_TYPE    = 16'h86DD;
  localparam logic [16:0] IPV4_LEN_OFS = 17'd14;
  localparam logic [16:0] IPV6_LEN_OFS = 17'd54;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ACCEPT,
    W_DROP
  } wr_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/pkt_fifo_ram.sv
// Simple dual-port RAM with one-cycle registered read; read data holds while re is low.
module pkt_fifo_ram #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ingress_pkt_filter.sv
// Ingress header check, FEP rewrite and store-and-forward buffer for MRMAC RX frames.
// Define INGRESS_IPV6_EN to accept IPv6 (0x86DD) frames; otherwise they are header drops.
module ingress_pkt_filter
  import ingress_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int FIFO_DEPTH = 64,
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1514
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic [31:0]                   pkt_cnt,
  output logic [31:0]                   drop_hdr_cnt,
  output logic [31:0]                   drop_ovf_cnt,
  output logic [31:0]                   len_err_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int BB_W       = $clog2(BEAT_BYTES);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int PW         = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
  localparam logic [16:0]   MIN_L   = 17'(MIN_LEN);
  localparam logic [16:0]   MAX_L   = 17'(MAX_LEN);
  localparam logic [16:0]   ROUND   = 17'(BEAT_BYTES - 1);

  wr_state_t state_q, state_n;
  logic [PW-1:0] wr_ptr_q, wr_ptr_n, wr_cmt_q, wr_cmt_n, rd_ptr_q, rd_ptr_n, rd_addr_q;
  logic [16:0]   exp_q, exp_n, cnt_q, cnt_n, cnt_inc;
  logic          rdy_q, beat;
  logic          wr_en, inc_pkt, inc_hdr, inc_ovf, inc_len;

  logic [15:0]           etype, frame_len;
  logic [16:0]           len_sum, hdr_exp;
  logic                  is_ip, hdr_ok, space_ok;
  logic [PW-1:0]         free;
  logic [DATA_WIDTH-1:0] first_data, wr_data;

  always_comb begin
    etype   = {s_axis_tdata[103:96], s_axis_tdata[111:104]};
    is_ip   = 1'b0;
    len_sum = '0;
    if (etype == IPV4_TYPE) begin
      is_ip   = 1'b1;
      len_sum = {1'b0, s_axis_tdata[135:128], s_axis_tdata[143:136]} + IPV4_LEN_OFS;
    end
`ifdef INGRESS_IPV6_EN
    else if (etype == IPV6_TYPE) begin
      is_ip   = 1'b1;
      len_sum = {1'b0, s_axis_tdata[151:144], s_axis_tdata[159:152]} + IPV6_LEN_OFS;
    end
`endif
    frame_len = len_sum[15:0];
    // len_sum[16] is the 16-bit carry; it fails the check on its own
    hdr_ok    = is_ip && !len_sum[16] && (len_sum >= MIN_L) && (len_sum <= MAX_L);
    hdr_exp   = (len_sum + ROUND) >> BB_W;
    free      = DEPTH_P - (wr_ptr_q - rd_ptr_q);
    space_ok  = 17'(free) >= hdr_exp;
    first_data          = s_axis_tdata;
    first_data[95:48]   = FEP_HEADER;
    first_data[47:32]   = frame_len;
    first_data[31:16]   = frame_len;
    first_data[15:0]    = frame_len;
    wr_data   = (state_q == W_IDLE) ? first_data : s_axis_tdata;
  end

  assign beat    = s_axis_tvalid && rdy_q;
  assign cnt_inc = cnt_q + 17'd1;

  always_comb begin
    state_n  = state_q;
    wr_ptr_n = wr_ptr_q;
    wr_cmt_n = wr_cmt_q;
    exp_n    = exp_q;
    cnt_n    = cnt_q;
    wr_en    = 1'b0;
    inc_pkt  = 1'b0;
    inc_hdr  = 1'b0;
    inc_ovf  = 1'b0;
    inc_len  = 1'b0;
    case (state_q)
      W_IDLE: if (beat) begin
        if (!hdr_ok || !space_ok) begin
          inc_hdr = !hdr_ok;
          inc_ovf = hdr_ok;
          if (!s_axis_tlast) state_n = W_DROP;
        end else begin
          wr_en    = 1'b1;
          wr_ptr_n = wr_ptr_q + 1'b1;
          exp_n    = hdr_exp;
          cnt_n    = 17'd1;
          if (s_axis_tlast && hdr_exp == 17'd1) begin
            wr_cmt_n = wr_ptr_q + 1'b1;
            inc_pkt  = 1'b1;
          end else if (s_axis_tlast) begin
            wr_ptr_n = wr_cmt_q;
            inc_len  = 1'b1;
          end else if (hdr_exp == 17'd1) begin
            wr_ptr_n = wr_cmt_q;
            inc_len  = 1'b1;
            state_n  = W_DROP;
          end else begin
            state_n  = W_ACCEPT;
          end
        end
      end
      W_ACCEPT: if (beat) begin
        wr_en    = 1'b1;
        wr_ptr_n = wr_ptr_q + 1'b1;
        cnt_n    = cnt_inc;
        if (s_axis_tlast && cnt_inc == exp_q) begin
          wr_cmt_n = wr_ptr_q + 1'b1;
          inc_pkt  = 1'b1;
          state_n  = W_IDLE;
        end else if (s_axis_tlast || cnt_inc == exp_q) begin
          wr_ptr_n = wr_cmt_q;
          inc_len  = 1'b1;
          state_n  = s_axis_tlast ? W_IDLE : W_DROP;
        end
      end
      W_DROP: if (beat && s_axis_tlast) state_n = W_IDLE;
      default: state_n = W_IDLE;
    endcase
  end

  // Read side: RAM read register feeds an output register; rd_ptr frees slots only on egress handshake.
  logic [DATA_WIDTH:0]   ram_rdata;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  ram_last, s1_vld_q, out_rdy, s1_adv, rd_issue, rd_first_q;
  logic [BB_W-1:0]       len_q, rem;
  logic [BEAT_BYTES-1:0] keep_calc;

  pkt_fifo_ram #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({s_axis_tlast, wr_data}),
    .re    (rd_issue),
    .raddr (rd_addr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  always_comb begin
    ram_last = ram_rdata[DATA_WIDTH];
    ram_data = ram_rdata[DATA_WIDTH-1:0];
    out_rdy  = !m_axis_tvalid || m_axis_tready;
    s1_adv   = s1_vld_q && out_rdy;
    rd_issue = (rd_addr_q != wr_cmt_q) && (!s1_vld_q || s1_adv);
    rd_ptr_n = rd_ptr_q + PW'(m_axis_tvalid && m_axis_tready);
    rem      = rd_first_q ? ram_data[BB_W-1:0] : len_q;
    for (int unsigned i = 0; i < BEAT_BYTES; i++)
      keep_calc[i] = !ram_last || (rem == '0) || (BB_W'(i) < rem);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= W_IDLE;
      wr_ptr_q      <= '0;
      wr_cmt_q      <= '0;
      rd_ptr_q      <= '0;
      rd_addr_q     <= '0;
      exp_q         <= '0;
      cnt_q         <= '0;
      rdy_q         <= 1'b0;
      pkt_cnt       <= '0;
      drop_hdr_cnt  <= '0;
      drop_ovf_cnt  <= '0;
      len_err_cnt   <= '0;
      fifo_level    <= '0;
      s1_vld_q      <= 1'b0;
      rd_first_q    <= 1'b1;
      len_q         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tkeep  <= '0;
    end else begin
      state_q      <= state_n;
      wr_ptr_q     <= wr_ptr_n;
      wr_cmt_q     <= wr_cmt_n;
      rd_ptr_q     <= rd_ptr_n;
      exp_q        <= exp_n;
      cnt_q        <= cnt_n;
      rdy_q        <= 1'b1;
      pkt_cnt      <= sat_inc(pkt_cnt, inc_pkt);
      drop_hdr_cnt <= sat_inc(drop_hdr_cnt, inc_hdr);
      drop_ovf_cnt <= sat_inc(drop_ovf_cnt, inc_ovf);
      len_err_cnt  <= sat_inc(len_err_cnt, inc_len);
      fifo_level   <= wr_cmt_n - rd_ptr_n;
      if (rd_issue) rd_addr_q <= rd_addr_q + 1'b1;
      s1_vld_q <= rd_issue || (s1_vld_q && !s1_adv);
      if (s1_adv) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= ram_data;
        m_axis_tlast  <= ram_last;
        m_axis_tkeep  <= keep_calc;
        rd_first_q    <= ram_last;
        if (rd_first_q) len_q <= ram_data[BB_W-1:0];
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  assign s_axis_tready = rdy_q;

endmodule
